// File: rtl/serial_link_pkg.sv
// Shared definitions for the 7-bit single-wire serial link (transmitter and receiver sides).
package serial_link_pkg;

    localparam int DATA_BITS = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Even parity: the data bits plus this bit XOR to zero.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period divider: strobes bit_end in the last clock of each bit period while running.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    input  logic restart,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_reg;

    assign bit_end = run && (cnt_reg == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else if (restart || !run || bit_end) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/serial_transmitter.sv
// Parallel-to-serial transmitter: start, 7 data bits MSB first, even parity, stop bits,
// with a one-word holding register so the producer can queue the next word mid-frame.
module serial_transmitter
    import serial_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

    tx_state_t            state_reg, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 parity_reg, parity_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic [SW-1:0]        stop_cnt_reg, stop_cnt_next;
    logic [DATA_BITS-1:0] hold_reg, hold_next;
    logic                 hold_full_reg, hold_full_next;
    logic                 serial_out_reg, line_next;
    logic                 accept, frame_end, load, bit_end;

    serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .run     (state_reg != IDLE),
        .restart (load),
        .bit_end (bit_end)
    );

    assign accept    = tx_valid && !hold_full_reg;
    assign frame_end = (state_reg == STOP) && bit_end && (stop_cnt_reg == STOP_LAST);

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        parity_next    = parity_reg;
        bit_idx_next   = bit_idx_reg;
        stop_cnt_next  = stop_cnt_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        load           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next  = START;
                    shift_next  = data_in;
                    parity_next = even_parity(data_in);
                    load        = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd6;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == 3'd0) begin
                        state_next = PARITY;
                    end else begin
                        bit_idx_next = bit_idx_reg - 3'd1;
                        shift_next   = {shift_reg[DATA_BITS-2:0], 1'b0};
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next    = STOP;
                    stop_cnt_next = '0;
                end
            end
            STOP: begin
                if (frame_end) begin
                    // A word arriving in the final stop cycle chains straight into the shifter.
                    if (hold_full_reg) begin
                        state_next     = START;
                        shift_next     = hold_reg;
                        parity_next    = even_parity(hold_reg);
                        hold_full_next = 1'b0;
                        load           = 1'b1;
                    end else if (accept) begin
                        state_next  = START;
                        shift_next  = data_in;
                        parity_next = even_parity(data_in);
                        load        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (bit_end) begin
                    stop_cnt_next = stop_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (accept && (state_reg != IDLE) && !frame_end) begin
            hold_next      = data_in;
            hold_full_next = 1'b1;
        end

        case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = shift_next[DATA_BITS-1];
            PARITY:  line_next = parity_next;
            default: line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            parity_reg     <= 1'b0;
            bit_idx_reg    <= '0;
            stop_cnt_reg   <= '0;
            hold_reg       <= '0;
            hold_full_reg  <= 1'b0;
            serial_out_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            parity_reg     <= parity_next;
            bit_idx_reg    <= bit_idx_next;
            stop_cnt_reg   <= stop_cnt_next;
            hold_reg       <= hold_next;
            hold_full_reg  <= hold_full_next;
            serial_out_reg <= line_next;
        end
    end

    assign tx_ready   = !hold_full_reg;
    assign serial_out = serial_out_reg;
    assign busy       = (state_reg != IDLE);
    assign frame_done = frame_end;

endmodule
